// File: rtl/fetch_unit.sv
// rv32i instruction-fetch front end: PC, one-outstanding imem read,
// single output slot, stall/redirect handling with stale-fetch drop.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  output logic        misaligned_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_drop_addr;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_inst_valid;
  logic        r_mis;

  logic        w_req;
  logic [31:0] w_pc_inc;
  logic [31:0] w_tgt;
  logic [31:0] w_inst;

  assign w_pc_inc = r_pc + 32'd4;
  assign w_tgt    = {redirect_pc[31:2], 2'b00};

  always_comb begin
    w_req = 1'b0;
    case (r_state)
      S_IDLE:  w_req = !redirect && (!r_inst_valid || !stall);
      S_WAIT:  w_req = 1'b1;
      S_DROP:  w_req = 1'b1;
      default: w_req = 1'b0;
    endcase
  end

  // DROP keeps presenting the abandoned address until memory answers
  assign imem_req  = rst_n && w_req;
  assign imem_addr = (r_state == S_DROP) ? r_drop_addr : r_pc;

  assign w_inst         = r_inst_valid ? r_inst : NOP_INST;
  assign inst           = w_inst;
  assign inst_valid     = r_inst_valid;
  assign inst_pc        = r_inst_pc;
  assign opcode         = w_inst[6:0];
  assign misaligned_err = r_mis;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_drop_addr  <= RESET_PC;
      r_inst       <= NOP_INST;
      r_inst_pc    <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_mis        <= 1'b0;
    end else begin
      if (r_inst_valid && !stall)
        r_inst_valid <= 1'b0;
      if (redirect) begin
        r_inst_valid <= 1'b0;
        r_pc         <= w_tgt;
        if (|redirect_pc[1:0])
          r_mis <= 1'b1;
        case (r_state)
          S_WAIT: begin
            r_drop_addr <= r_pc;
            r_state     <= imem_ack ? S_IDLE : S_DROP;
          end
          S_DROP:
            if (imem_ack)
              r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end else begin
        case (r_state)
          S_IDLE:
            if (w_req) begin
              if (imem_ack) begin
                r_inst       <= imem_rdata;
                r_inst_pc    <= r_pc;
                r_inst_valid <= 1'b1;
                r_pc         <= w_pc_inc;
              end else begin
                r_state <= S_WAIT;
              end
            end
          S_WAIT:
            if (imem_ack) begin
              r_inst       <= imem_rdata;
              r_inst_pc    <= r_pc;
              r_inst_valid <= 1'b1;
              r_pc         <= w_pc_inc;
              r_state      <= S_IDLE;
            end
          S_DROP:
            if (imem_ack)
              r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural imem of
// programmable ack latency.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic        misaligned_err;

  int n_chk = 0;
  int n_fail = 0;
  int lat = 0;
  int cnt;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .opcode(opcode),
    .misaligned_err(misaligned_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a ^ {25'd0, a[8:2]};
  endfunction

  // memory acks once a request has been pending for lat cycles
  always @(posedge clk) begin
    if (!rst_n) cnt <= 0;
    else if (imem_req && !imem_ack) cnt <= cnt + 1;
    else cnt <= 0;
  end
  assign imem_ack   = imem_req && (cnt >= lat);
  assign imem_rdata = mw(imem_addr);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_pc = '0; lat = 0;
    tick(); tick();
    n_chk++;
    if ({imem_req, inst_valid, misaligned_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 000",
               {imem_req, inst_valid, misaligned_err});
    end
    n_chk++;
    if ({inst, inst_pc, opcode} !== {NOP, 32'h0, 7'h13}) begin
      n_fail++;
      $display("FAIL reset_slot got %h/%h want %h/0", inst, inst_pc, NOP);
    end
  endtask

  task automatic test_zero_wait;
    rst_n = 1'b1;
    #1;
    n_chk++;
    if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL first_req got %b %h %b want 1 0 0",
               imem_req, imem_addr, inst_valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if ({inst_valid, inst_pc, inst, opcode, imem_addr} !==
          {1'b1, 32'(4*i), mw(32'(4*i)), mw(32'(4*i))[6:0], 32'(4*i+4)}) begin
        n_fail++;
        $display("FAIL zw_stream[%0d] got v=%b pc=%h i=%h a=%h want pc=%h",
                 i, inst_valid, inst_pc, inst, imem_addr, 32'(4*i));
      end
    end
  endtask

  task automatic test_wait_mem;
    logic [31:0] exp;
    int n;
    exp = 32'd20;
    lat = 3;
    #1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!imem_ack && n < 10) begin
        n_chk++;
        if ({imem_req, imem_addr} !== {1'b1, exp}) begin
          n_fail++;
          $display("FAIL wait_hold got %b %h want 1 %h", imem_req, imem_addr, exp);
        end
        tick();
        n++;
      end
      n_chk++;
      if (n !== 3 || imem_addr !== exp) begin
        n_fail++;
        $display("FAIL wait_ack got n=%0d a=%h want 3 %h", n, imem_addr, exp);
      end
      tick();
      n_chk++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, exp, mw(exp)}) begin
        n_fail++;
        $display("FAIL wait_cap got %b %h %h want 1 %h", inst_valid, inst_pc, inst, exp);
      end
      exp = exp + 32'd4;
    end
  endtask

  task automatic test_stall;
    lat = 0;
    #1;
    n_chk++;
    if ({imem_req, imem_ack, imem_addr} !== {2'b11, 32'd32}) begin
      n_fail++;
      $display("FAIL stall_pre got %b%b %h want 11 20", imem_req, imem_ack, imem_addr);
    end
    tick();
    stall = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({imem_req, inst_valid, inst_pc, inst} !== {2'b01, 32'd32, mw(32'd32)}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got r=%b v=%b pc=%h want 0 1 20",
                 i, imem_req, inst_valid, inst_pc);
      end
      tick();
    end
    stall = 1'b0;
    #1;
    n_chk++;
    if ({imem_req, imem_addr, inst_pc} !== {1'b1, 32'd36, 32'd32}) begin
      n_fail++;
      $display("FAIL stall_rel got %b %h %h want 1 24 20", imem_req, imem_addr, inst_pc);
    end
    tick();
    n_chk++;
    if ({inst_valid, inst_pc, imem_addr} !== {1'b1, 32'd36, 32'd40}) begin
      n_fail++;
      $display("FAIL stall_next got %b %h %h want 1 24 28", inst_valid, inst_pc, imem_addr);
    end
  endtask

  task automatic test_redirect_drop;
    int n;
    lat = 3;
    tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    #1;
    n_chk++;
    if ({imem_req, imem_addr} !== {1'b1, 32'd40}) begin
      n_fail++;
      $display("FAIL rd_wait got %b %h want 1 28", imem_req, imem_addr);
    end
    tick();
    redirect = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if ({imem_req, imem_addr, inst_valid, inst} !== {1'b1, 32'd40, 1'b0, NOP}) begin
        n_fail++;
        $display("FAIL rd_drop[%0d] got %b %h %b %h want 1 28 0 13",
                 i, imem_req, imem_addr, inst_valid, inst);
      end
      tick();
    end
    n = 0;
    while (!imem_ack && n < 10) begin
      n_chk++;
      if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h100, 1'b0}) begin
        n_fail++;
        $display("FAIL rd_newreq got %b %h %b want 1 100 0",
                 imem_req, imem_addr, inst_valid);
      end
      tick();
      n++;
    end
    n_chk++;
    if (n !== 3) begin
      n_fail++;
      $display("FAIL rd_ack got n=%0d want 3", n);
    end
    tick();
    n_chk++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h100, mw(32'h100)}) begin
      n_fail++;
      $display("FAIL rd_cap got %b %h %h want 1 100", inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_misaligned;
    lat = 0;
    redirect = 1'b1; redirect_pc = 32'h202;
    #1;
    n_chk++;
    if ({imem_req, misaligned_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL mis_pre got %b%b want 00", imem_req, misaligned_err);
    end
    tick();
    redirect = 1'b0;
    #1;
    n_chk++;
    if ({inst_valid, misaligned_err, imem_req, imem_addr} !== {3'b011, 32'h200}) begin
      n_fail++;
      $display("FAIL mis_set got v=%b e=%b r=%b a=%h want 0 1 1 200",
               inst_valid, misaligned_err, imem_req, imem_addr);
    end
    tick();
    n_chk++;
    if ({inst_valid, inst_pc, misaligned_err} !== {1'b1, 32'h200, 1'b1}) begin
      n_fail++;
      $display("FAIL mis_cap got %b %h %b want 1 200 1", inst_valid, inst_pc, misaligned_err);
    end
  endtask

  task automatic test_wrap;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    #1;
    n_chk++;
    if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_fail++;
      $display("FAIL wrap_req got %b %h want 1 fffffffc", imem_req, imem_addr);
    end
    tick();
    n_chk++;
    if ({inst_valid, inst_pc, imem_addr} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
      n_fail++;
      $display("FAIL wrap_step got %b %h %h want 1 fffffffc 0",
               inst_valid, inst_pc, imem_addr);
    end
    tick();
    n_chk++;
    if ({inst_valid, inst_pc, misaligned_err} !== {1'b1, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_zero got %b %h %b want 1 0 1", inst_valid, inst_pc, misaligned_err);
    end
  endtask

  task automatic test_reset_mid_wait;
    lat = 3;
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    tick();
    n_chk++;
    if ({imem_req, imem_addr, imem_ack} !== {1'b1, 32'h40, 1'b0}) begin
      n_fail++;
      $display("FAIL rstw_pre got %b %h %b want 1 40 0", imem_req, imem_addr, imem_ack);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rstw_req_low got %b want 0", imem_req);
    end
    tick();
    n_chk++;
    if ({imem_req, inst_valid, inst, inst_pc, misaligned_err} !==
        {2'b00, NOP, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL rstw_state got r=%b v=%b i=%h pc=%h e=%b want 0 0 13 0 0",
               imem_req, inst_valid, inst, inst_pc, misaligned_err);
    end
    rst_n = 1'b1; lat = 0;
    #1;
    n_chk++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL rstw_first got %b %h want 1 0", imem_req, imem_addr);
    end
    tick();
    n_chk++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h0, mw(32'h0)}) begin
      n_fail++;
      $display("FAIL rstw_cap got %b %h %h want 1 0", inst_valid, inst_pc, inst);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_mem();
    test_stall();
    test_redirect_drop();
    test_misaligned();
    test_wrap();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
